rc4_ksa_ctrl: RTL and testbench

RC4_KSA_CTRL -- requirements
Module: rc4_ksa_ctrl

---
 rtl/rc4_ksa_ctrl.sv | 178 +++++++++++++++++
 tb/tb_rc4_ksa_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rc4_ksa_ctrl.sv
// RC4 state init plus key-scheduling controller driving an external 256x32 RAM.
// Latency: done pulses 1281 cycles after start is accepted (256 init + 1024 KSA + 1).
// No backpressure: start is taken only in IDLE, and the RAM must accept one access per cycle.
// Optional macro RC4_KEY_LATCH_EN: captures key when start is accepted; otherwise key is used live.
module rc4_ksa_ctrl #(
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic                   busy,
  output logic                   done,
  output logic [31:0]            mem_d,
  output logic [7:0]             mem_waddr,
  output logic [7:0]             mem_raddr,
  output logic                   mem_we,
  input  logic [31:0]            mem_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    RDI   = 3'd2,
    RDJ   = 3'd3,
    SWAP1 = 3'd4,
    SWAP2 = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Key byte index runs alongside i so no modulo divider is needed.
  localparam logic [3:0] KIDX_MAX = 4'(KEY_BYTES - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [7:0]             i_q;
  logic [7:0]             j_q;
  logic [7:0]             si_q;
  logic [3:0]             kidx_q;
  logic [7:0]             key_byte;
  logic [7:0]             j_new;
  logic [8*KEY_BYTES-1:0] key_use;
  logic                   accept;
  logic                   unused_q;

  assign accept   = (state == IDLE) && start;
  assign unused_q = ^mem_q[31:8];

`ifdef RC4_KEY_LATCH_EN
  logic [8*KEY_BYTES-1:0] key_q;

  // Snapshot the key when a run is accepted so the caller may change it mid-run.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (accept) begin
      key_q <= key;
    end
  end

  assign key_use = key_q;
`else
  assign key_use = key;
`endif

  // Select key byte kidx; byte 0 sits in the most significant position.
  always_comb begin
    key_byte = '0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      if (kidx_q == 4'(n)) begin
        key_byte = key_use[8*KEY_BYTES-1-8*n -: 8];
      end
    end
  end

  // S[i] arrives on mem_q during RDJ; the new j is used as the read address that same cycle.
  assign j_new = j_q + mem_q[7:0] + key_byte;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and RAM/handshake outputs decoded from the current state.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_d     = '0;
    mem_raddr = i_q;
    case (state)
      IDLE: begin
        if (start) state_nxt = INIT;
      end
      INIT: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = i_q;
        mem_d     = {24'h0, i_q};
        if (i_q == 8'hFF) state_nxt = RDI;
      end
      RDI: begin
        busy      = 1'b1;
        mem_raddr = i_q;
        state_nxt = RDJ;
      end
      RDJ: begin
        busy      = 1'b1;
        mem_raddr = j_new;
        state_nxt = SWAP1;
      end
      SWAP1: begin
        // S[i] <= S[j]; when i==j this rewrites the same value and SWAP2 restores si.
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = i_q;
        mem_d     = {24'h0, mem_q[7:0]};
        state_nxt = SWAP2;
      end
      SWAP2: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = j_q;
        mem_d     = {24'h0, si_q};
        state_nxt = (i_q == 8'hFF) ? DONE : RDI;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Index, accumulator, saved S[i] and key-byte index updates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_q    <= '0;
      j_q    <= '0;
      si_q   <= '0;
      kidx_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            i_q    <= '0;
            j_q    <= '0;
            kidx_q <= '0;
          end
        end
        INIT: begin
          i_q <= i_q + 8'd1;
        end
        RDJ: begin
          si_q <= mem_q[7:0];
          j_q  <= j_new;
        end
        SWAP2: begin
          if (i_q != 8'hFF) begin
            i_q    <= i_q + 8'd1;
            kidx_q <= (kidx_q == KIDX_MAX) ? 4'd0 : kidx_q + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_ctrl.sv
// Directed bench for rc4_ksa_ctrl with a behavioural registered-read RAM.
// Checks reset, init abort, full key schedules against a software RC4 model, start filtering.
// Expected permutations come from a straightforward software KSA.
module tb_rc4_ksa_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [23:0] key;
  logic        busy;
  logic        done;
  logic [31:0] mem_d;
  logic [7:0]  mem_waddr;
  logic [7:0]  mem_raddr;
  logic        mem_we;
  logic [31:0] mem_q;

  logic [31:0] ram [256];
  logic [7:0]  exp_s [256];
  int          vecs = 0;
  int          fails = 0;
  int          wr_cnt = 0;
  int          hi_bad = 0;
  int          dcyc;

  rc4_ksa_ctrl #(.KEY_BYTES(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key       (key),
    .busy      (busy),
    .done      (done),
    .mem_d     (mem_d),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_we    (mem_we),
    .mem_q     (mem_q)
  );

  always #5 clk = ~clk;

  // 256x32 RAM: write on edge, read data registered one cycle after the address.
  always @(posedge clk) begin
    if (mem_we === 1'b1) ram[mem_waddr] <= mem_d;
    mem_q <= ram[mem_raddr];
  end

  // Count writes and any write carrying nonzero upper data bits.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_cnt = wr_cnt + 1;
      if (mem_d[31:8] !== 24'h0) hi_bad = hi_bad + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference RC4 KSA for a 3-byte key, byte 0 in bits [23:16].
  task automatic model(input logic [23:0] k);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    for (int a = 0; a < 256; a++) exp_s[a] = 8'(a);
    j = 8'h00;
    for (int a = 0; a < 256; a++) begin
      kb = k[23 - 8*(a % 3) -: 8];
      j = j + exp_s[a] + kb;
      t = exp_s[a];
      exp_s[a] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic check_ram(input logic [23:0] k);
    model(k);
    for (int a = 0; a < 256; a++)
      chk($sformatf("ram[%0d]", a), ram[a], {24'h0, exp_s[a]});
  endtask

  // Start a run and watch it until done; optional extra start pulses while busy/DONE.
  task automatic run(input logic [23:0] k, input bit pulses, output int dc);
    logic [7:0] kb0;
    kb0   = k[23:16];
    key   = k;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dc = -1;
    for (int n = 1; n <= 2000; n++) begin
      if (pulses) start = (n == 10 || n == 500 || n == 1281);
`ifdef RC4_KEY_LATCH_EN
      if (n == 300) key = 24'hFFFFFF;
`endif
      @(negedge clk);
      if (n == 1) begin
        chk("init_busy", 32'(busy), 32'd1);
        chk("init_first", 32'({mem_we, mem_waddr, mem_d[7:0]}), 32'({1'b1, 8'h00, 8'h00}));
      end
      if (n == 256) chk("init_last", 32'({mem_we, mem_waddr, mem_d[7:0]}), 32'({1'b1, 8'hFF, 8'hFF}));
      if (n == 257) chk("rdi_raddr", 32'({busy, mem_we, mem_raddr}), 32'({1'b1, 1'b0, 8'h00}));
      if (n == 258) chk("rdj_raddr", 32'({mem_we, mem_raddr}), 32'({1'b0, kb0}));
      if (n == 259) chk("swap1", 32'({mem_we, mem_waddr, mem_d[7:0]}), 32'({1'b1, 8'h00, kb0}));
      if (n == 260) chk("swap2", 32'({mem_we, mem_waddr, mem_d[7:0]}), 32'({1'b1, kb0, 8'h00}));
      if (n == 261) chk("iter0_s0", ram[0], {24'h0, kb0});
      if (done === 1'b1) begin
        chk("done_busy_we", 32'({busy, mem_we}), 32'd0);
        dc = n;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int seen [256];
    rst_n = 1'b0;
    start = 1'b0;
    key   = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy_done", 32'({busy, done}), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_waddr", 32'(mem_waddr), 32'd0);
    chk("rst_d", mem_d, 32'd0);

    // Reset asserted together with start must win.
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_beats_start", 32'({busy, mem_we}), 32'd0);
    @(posedge clk); #1;

    // Init only, then reset in cycle 257: identity permutation, no further writes.
    key    = 24'h123456;
    wr_cnt = 0;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (255) @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("abort_wr_cnt", 32'(wr_cnt), 32'd256);
    chk("abort_idle", 32'({busy, done}), 32'd0);
    for (int a = 0; a < 256; a++) chk($sformatf("init[%0d]", a), ram[a], 32'(a));
    @(posedge clk); #1;

    // All-zero key: j hits i on iteration 0, S[0] must stay 0.
    run(24'h000000, 1'b0, dcyc);
    chk("done_cycle_k0", 32'(dcyc), 32'd1281);
    check_ram(24'h000000);

    // Extra start pulses while busy and in DONE are ignored.
    run(24'h4A2F19, 1'b1, dcyc);
    chk("done_cycle_k1", 32'(dcyc), 32'd1281);
    @(negedge clk);
    chk("single_done", 32'({busy, done}), 32'd0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("no_queued_run", 32'({busy, done, mem_we}), 32'd0);
    check_ram(24'h4A2F19);
    for (int v = 0; v < 256; v++) seen[v] = 0;
    for (int a = 0; a < 256; a++) seen[ram[a][7:0]]++;
    for (int v = 0; v < 256; v++) chk($sformatf("perm[%0d]", v), 32'(seen[v]), 32'd1);
    @(posedge clk); #1;

    // Fresh start from IDLE runs normally.
    run(24'h010203, 1'b0, dcyc);
    chk("done_cycle_k2", 32'(dcyc), 32'd1281);
    check_ram(24'h010203);

    chk("hi_bits_zero", 32'(hi_bad), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
